// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 keyboard front end: frame deserialiser, scancode protocol FSM,
// ASCII lookup and a character FIFO with a valid/ready consumer port.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ascii_rdy,
  output logic       ascii_valid,
  output logic [7:0] ascii_out,
  output logic       key_down,
  output logic [7:0] last_code,
  output logic [7:0] press_cnt,
  output logic       overflow,
  output logic       frame_err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          ps2_fall;
  logic          ps2_bit;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_sh;
  logic [TW-1:0] idle_cnt;
  logic          code_vld;
  logic [7:0]    code;

  // Sync flops idle high so that reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign ps2_fall = clk_sync[2] & ~clk_sync[1];
  assign ps2_bit  = data_sync[1];

  // After ten shifts: [0]=start, [8:1]=data, [9]=parity; the stop bit is live.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= 4'd0;
      frame_sh  <= 10'd0;
      idle_cnt  <= '0;
      code_vld  <= 1'b0;
      code      <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      code_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (ps2_fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (!frame_sh[0] && ps2_bit && (^frame_sh[9:1])) begin
            code_vld <= 1'b1;
            code     <= frame_sh[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          frame_sh <= {ps2_bit, frame_sh[9:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
          idle_cnt  <= '0;
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  logic       map_hit;
  logic [7:0] map_char;
  logic [7:0] ascii;
  logic       shift_key;

  always_comb begin
    map_hit  = 1'b1;
    map_char = 8'h00;
    case (code)
      8'h1C: map_char = 8'h61;  8'h32: map_char = 8'h62;  8'h21: map_char = 8'h63;
      8'h23: map_char = 8'h64;  8'h24: map_char = 8'h65;  8'h2B: map_char = 8'h66;
      8'h34: map_char = 8'h67;  8'h33: map_char = 8'h68;  8'h43: map_char = 8'h69;
      8'h3B: map_char = 8'h6A;  8'h42: map_char = 8'h6B;  8'h4B: map_char = 8'h6C;
      8'h3A: map_char = 8'h6D;  8'h31: map_char = 8'h6E;  8'h44: map_char = 8'h6F;
      8'h4D: map_char = 8'h70;  8'h15: map_char = 8'h71;  8'h2D: map_char = 8'h72;
      8'h1B: map_char = 8'h73;  8'h2C: map_char = 8'h74;  8'h3C: map_char = 8'h75;
      8'h2A: map_char = 8'h76;  8'h1D: map_char = 8'h77;  8'h22: map_char = 8'h78;
      8'h35: map_char = 8'h79;  8'h1A: map_char = 8'h7A;
      8'h45: map_char = 8'h30;  8'h16: map_char = 8'h31;  8'h1E: map_char = 8'h32;
      8'h26: map_char = 8'h33;  8'h25: map_char = 8'h34;  8'h2E: map_char = 8'h35;
      8'h36: map_char = 8'h36;  8'h3D: map_char = 8'h37;  8'h3E: map_char = 8'h38;
      8'h46: map_char = 8'h39;
      default: map_hit = 1'b0;
    endcase
  end

  state_t     state, state_next;
  logic       shift, shift_next;
  logic       key_down_next;
  logic [7:0] held, held_next;
  logic [7:0] last_code_next;
  logic [7:0] press_cnt_next;
  logic       push;

  // Letters carry bit 6 set; digits do not, so only letters are shifted.
  assign ascii     = (map_char[6] && shift) ? (map_char - 8'h20) : map_char;
  assign shift_key = (code == 8'h12) || (code == 8'h59);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      shift     <= 1'b0;
      key_down  <= 1'b0;
      held      <= 8'h00;
      last_code <= 8'h00;
      press_cnt <= 8'h00;
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      key_down  <= key_down_next;
      held      <= held_next;
      last_code <= last_code_next;
      press_cnt <= press_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift;
    key_down_next  = key_down;
    held_next      = held;
    last_code_next = last_code;
    press_cnt_next = press_cnt;
    push           = 1'b0;
    if (code_vld) begin
      case (state)
        IDLE: begin
          if (code == 8'hF0) begin
            state_next = BRK;
          end else if (code == 8'hE0) begin
            state_next = EXT;
          end else if (shift_key) begin
            shift_next = 1'b1;
          end else begin
            last_code_next = code;
            if (map_hit) begin
              push = 1'b1;
              // A repeat of the held key is typematic: it pushes but is not a new press.
              if (!key_down || code != held) begin
                press_cnt_next = press_cnt + 8'd1;
                held_next      = code;
                key_down_next  = 1'b1;
              end
            end
          end
        end
        BRK: begin
          state_next = IDLE;
          if (shift_key) shift_next = 1'b0;
          else if (code == held) key_down_next = 1'b0;
        end
        EXT:     state_next = (code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_next;
  logic        empty, full, pop, wr_en;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = !empty && ascii_rdy;
  assign wr_en       = push && (!full || pop);
  assign rd_next     = rd_ptr + {{AW{1'b0}}, pop};
  assign ascii_valid = !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= ascii;
  end

  // The head register bypasses the write when the new entry becomes the head.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ascii_out <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (push && full && !pop) overflow <= 1'b1;
      if (wr_en && (wr_ptr == rd_next)) ascii_out <= ascii;
      else if (pop || wr_en) ascii_out <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: bit-level PS/2 frames from a device
// model, compared against a scancode-level behavioural model.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 8;
  localparam int GAP   = 24;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ascii_rdy = 1'b1;
  logic       ascii_valid;
  logic [7:0] ascii_out;
  logic       key_down;
  logic [7:0] last_code;
  logic [7:0] press_cnt;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii_rdy(ascii_rdy), .ascii_valid(ascii_valid), .ascii_out(ascii_out),
    .key_down(key_down), .last_code(last_code), .press_cnt(press_cnt),
    .overflow(overflow), .frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int m_err = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};

  // Keyboard model state, tracked per received scancode
  bit         m_shift, m_kd, m_f0, m_e0;
  logic [7:0] m_held, m_last, m_press;

  always @(negedge clk) begin
    if (clrn && ascii_valid && ascii_rdy) got_q.push_back(ascii_out);
    if (clrn && frame_err) err_cnt++;
  end

  function automatic int model_char(input logic [7:0] c);
    for (int i = 0; i < 26; i++)
      if (c == letter_codes[i]) return (m_shift ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++)
      if (c == digit_codes[i]) return 'h30 + i;
    return -1;
  endfunction

  task automatic model_reset();
    m_shift = 0; m_kd = 0; m_f0 = 0; m_e0 = 0;
    m_held = 8'h00; m_last = 8'h00; m_press = 8'h00;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int ch;
    if (m_e0 && m_f0) begin
      m_e0 = 0; m_f0 = 0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1; else m_e0 = 0;
    end else if (m_f0) begin
      m_f0 = 0;
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      else if (b == m_held) m_kd = 0;
    end else if (b == 8'hF0) m_f0 = 1;
    else if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'h12 || b == 8'h59) m_shift = 1;
    else begin
      m_last = b;
      ch = model_char(b);
      if (ch >= 0) begin
        if (!m_kd || b != m_held) begin
          m_press = m_press + 8'd1; m_held = b; m_kd = 1;
        end
        exp_q.push_back(8'(ch));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) ascii_rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    tick(GAP + $urandom_range(0, 8));
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_byte(b);
  endtask

  function automatic logic [7:0] rand_mapped();
    if ($urandom_range(0, 2) == 0) return digit_codes[$urandom_range(0, 9)];
    return letter_codes[$urandom_range(0, 25)];
  endfunction

  task automatic test_reset();
    clrn = 1'b0;
    tick(3);
    @(negedge clk);
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ascii_valid); end
    checks++; if (ascii_out !== 8'h00) begin failures++; $display("FAIL rst_ascii got=%h exp=00", ascii_out); end
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rst_key_down got=%b exp=0", key_down); end
    checks++; if (last_code !== 8'h00) begin failures++; $display("FAIL rst_last_code got=%h exp=00", last_code); end
    checks++; if (press_cnt !== 8'h00) begin failures++; $display("FAIL rst_press_cnt got=%h exp=00", press_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    tick(1);
    clrn = 1'b1;
    model_reset();
    tick(4);
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    send_byte(8'h1C);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h61) begin failures++; $display("FAIL single_char got_n=%0d exp=61", got_q.size()); end
    checks++; if (press_cnt !== 8'd1) begin failures++; $display("FAIL single_press got=%0d exp=1", press_cnt); end
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL single_key_down got=%b exp=1", key_down); end
    checks++; if (last_code !== 8'h1C) begin failures++; $display("FAIL single_last_code got=%h exp=1c", last_code); end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (key_down !== m_kd) begin failures++; $display("FAIL single_release got=%b exp=%b", key_down, m_kd); end
    $display("test_single done");
  endtask

  task automatic test_seq(input string name, input logic [7:0] seq[$]);
    logic [7:0] last_before;
    got_q.delete(); exp_q.delete();
    last_before = m_last;
    foreach (seq[i]) send_byte(seq[i]);
    tick(GAP);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL %s_char[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]); end
    end
    checks++; if (press_cnt !== m_press) begin failures++; $display("FAIL %s_press got=%0d exp=%0d", name, press_cnt, m_press); end
    checks++; if (key_down !== m_kd) begin failures++; $display("FAIL %s_key_down got=%b exp=%b", name, key_down, m_kd); end
    checks++; if (last_code !== m_last) begin failures++; $display("FAIL %s_last_code got=%h exp=%h", name, last_code, m_last); end
    checks++; if (err_cnt != m_err) begin failures++; $display("FAIL %s_frame_err got=%0d exp=%0d", name, err_cnt, m_err); end
    $display("%s done chars=%0d press=%0d last_before=%h", name, got_q.size(), press_cnt, last_before);
  endtask

  task automatic test_errors();
    logic [7:0] p0;
    got_q.delete(); exp_q.delete();
    p0 = press_cnt;
    send_frame(8'h32, 1'b1, 1'b0); m_err++;
    send_frame(8'h1C, 1'b0, 1'b1); m_err++;
    checks++; if (err_cnt != m_err) begin failures++; $display("FAIL err_frames got=%0d exp=%0d", err_cnt, m_err); end
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL err_fifo got=%b exp=0", ascii_valid); end
    checks++; if (press_cnt !== p0) begin failures++; $display("FAIL err_press got=%0d exp=%0d", press_cnt, p0); end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    tick(TMO - 60);
    checks++; if (err_cnt != m_err) begin failures++; $display("FAIL err_early_timeout got=%0d exp=%0d", err_cnt, m_err); end
    tick(100);
    m_err++;
    checks++; if (err_cnt != m_err) begin failures++; $display("FAIL err_timeout got=%0d exp=%0d", err_cnt, m_err); end
    send_byte(8'h45);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h30) begin failures++; $display("FAIL err_recover got_n=%0d exp=30", got_q.size()); end
    send_byte(8'hF0); send_byte(8'h45);
    $display("test_errors done frame_errs=%0d", err_cnt);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h2B);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    clrn = 1'b0;
    tick(2);
    checks++; if (key_down !== 1'b0 || press_cnt !== 8'h00 || ascii_valid !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%0d/%b exp=0/0/0", key_down, press_cnt, ascii_valid); end
    clrn = 1'b1;
    model_reset();
    ps2_data = 1'b1;
    tick(GAP);
    send_byte(8'h1C);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h61) begin failures++; $display("FAIL midrst_resync got_n=%0d exp=61", got_q.size()); end
    checks++; if (press_cnt !== 8'd1 || err_cnt != m_err) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=1/%0d", press_cnt, err_cnt, m_err); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_random();
    logic [7:0] seq[$];
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0: seq.push_back(8'hF0);
        1: seq.push_back(8'hE0);
        2: seq.push_back(8'h12);
        3: seq.push_back(8'h59);
        4: seq.push_back(($urandom_range(0, 1) != 0) ? 8'h75 : 8'h05);
        default: seq.push_back(rand_mapped());
      endcase
    end
    seq.push_back(8'h75);
    seq.push_back(8'h75);
    rand_rdy = 1'b1;
    test_seq("random", seq);
    rand_rdy = 1'b0;
    ascii_rdy = 1'b1;
    tick(GAP);
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    ascii_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_byte(rand_mapped());
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_full_early got=%b exp=0", overflow); end
    checks++; if (ascii_valid !== 1'b1 || ascii_out !== exp_q[0]) begin failures++; $display("FAIL ovf_head got=%b/%h exp=1/%h", ascii_valid, ascii_out, exp_q[0]); end
    send_byte(rand_mapped());
    void'(exp_q.pop_back());
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    ascii_rdy = 1'b1;
    tick(DEPTH + 6);
    checks++; if (got_q.size() != DEPTH) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_char[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1 || ascii_valid !== 1'b0) begin failures++; $display("FAIL ovf_sticky got=%b/%b exp=1/0", overflow, ascii_valid); end
    $display("test_overflow done drained=%0d", got_q.size());
  endtask

  initial begin
    logic [7:0] s[$];
    model_reset();
    test_reset();
    test_single();
    s = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C, 8'hF0, 8'h1C};
    test_seq("shift", s);
    s = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    test_seq("typematic", s);
    test_errors();
    s = '{8'h2B, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h2B};
    test_seq("extended", s);
    test_reset_midframe();
    test_random();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
